// File: rtl/jt6295_sched.sv
// Voice scheduler for the jt6295 CPU write port: turns play/stop requests into
// MSM6295 command bytes, picks or steals a voice, and paces the wrn strobes.
module jt6295_sched #(
  parameter int WR_LEN = 4,
  parameter int WR_GAP = 8,
  parameter int SETTLE = 16,
  parameter int STEAL  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] req_phrase,
  input  logic [3:0] req_att,
  input  logic       stop_req,
  input  logic [3:0] stop_mask,
  output logic       ack,
  output logic       drop,
  output logic [1:0] ch,
  output logic       busy,
  output logic       wrn,
  output logic [7:0] din,
  input  logic [7:0] dout
);

  localparam int MAX_LEN = (WR_LEN > WR_GAP) ? ((WR_LEN > SETTLE) ? WR_LEN : SETTLE)
                                             : ((WR_GAP > SETTLE) ? WR_GAP : SETTLE);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LEN1 = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] GAP1 = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] SET1 = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_STOP_WR, S_STOP_GAP, S_P0_WR, S_P0_GAP, S_P1_WR, S_SETTLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    phrase;
  logic [3:0]    att;
  logic          steal;
  logic [1:0]    rr;
  logic          free_ok;
  logic [1:0]    free_ch;
  logic          unused_dout;

  // Only the four channel-busy flags matter; the rest of the status byte is ignored.
  assign unused_dout = ^dout[7:4];

  function automatic logic [3:0] onehot(input logic [1:0] n);
    return 4'b0001 << n;
  endfunction

  // NOTE: every output gets a default first, so this priority search cannot infer a latch.
  always_comb begin
    free_ok = 1'b0;
    free_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!dout[i]) begin
        free_ok = 1'b1;
        free_ch = 2'(i);
      end
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      phrase <= '0;
      att    <= '0;
      steal  <= 1'b0;
      rr     <= 2'd0;
      ack    <= 1'b0;
      drop   <= 1'b0;
      ch     <= 2'd0;
      busy   <= 1'b0;
      wrn    <= 1'b1;
      din    <= 8'h00;
    end else begin
      ack  <= 1'b0;
      drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (stop_req) begin
            if (stop_mask == 4'd0) begin
              ack <= 1'b1;
            end else begin
              din   <= {1'b0, stop_mask, 3'b000};
              wrn   <= 1'b0;
              cnt   <= LEN1;
              steal <= 1'b0;
              busy  <= 1'b1;
              state <= S_STOP_WR;
            end
          end else if (req) begin
            if (req_phrase == 7'd0) begin
              ack  <= 1'b1;
              drop <= 1'b1;
            end else begin
              phrase <= req_phrase;
              att    <= req_att;
              busy   <= 1'b1;
              state  <= S_PICK;
            end
          end
        end
        S_PICK: begin
          if (free_ok) begin
            ch    <= free_ch;
            din   <= {1'b1, phrase};
            wrn   <= 1'b0;
            cnt   <= LEN1;
            state <= S_P0_WR;
          end else if (STEAL != 0) begin
            // All voices busy: silence the round-robin victim, then reuse it.
            ch    <= rr;
            din   <= {1'b0, onehot(rr), 3'b000};
            wrn   <= 1'b0;
            cnt   <= LEN1;
            rr    <= rr + 2'd1;
            steal <= 1'b1;
            state <= S_STOP_WR;
          end else begin
            ack   <= 1'b1;
            drop  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_STOP_WR, S_P0_WR: begin
          if (cnt == '0) begin
            wrn   <= 1'b1;
            cnt   <= GAP1;
            state <= (state == S_STOP_WR) ? S_STOP_GAP : S_P0_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (steal) begin
            din   <= {1'b1, phrase};
            wrn   <= 1'b0;
            cnt   <= LEN1;
            state <= S_P0_WR;
          end else begin
            cnt   <= SET1;
            state <= S_SETTLE;
          end
        end
        S_P0_GAP: begin
          if (cnt == '0) begin
            din   <= {onehot(ch), att};
            wrn   <= 1'b0;
            cnt   <= LEN1;
            state <= S_P1_WR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_P1_WR: begin
          if (cnt == '0) begin
            wrn   <= 1'b1;
            cnt   <= SET1;
            state <= S_SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            ack   <= 1'b1;
            busy  <= 1'b0;
            steal <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jt6295_sched.md
# jt6295_sched

Voice scheduler sitting between sound-CPU-side requesters and the jt6295 CPU write port. Accepts phrase-play and stop requests, reads channel busy flags from the jt6295 status byte, picks a free voice (or steals one), and serialises the MSM6295 command bytes onto `wrn`/`din` with programmable strobe and gap lengths. Removes all command-byte formatting and channel bookkeeping from game cores.

## Interface
Parameters:
- `WR_LEN`, 4: clk cycles `wrn` is held low per byte (≥1).
- `WR_GAP`, 8: clk cycles `wrn` is held high between bytes (≥1).
- `SETTLE`, 16: clk cycles after the last byte before status is trusted again (≥1).
- `STEAL`, 0: 1 = when all voices are busy, stop a round-robin victim and reuse it; 0 = drop the request.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: play request, level; held until `ack`.
- `req_phrase` in 7: phrase number 1..127.
- `req_att` in 4: attenuation nibble.
- `stop_req` in 1: stop request, level; held until `ack`.
- `stop_mask` in 4: voices to stop, bit n = channel n.
- `ack` out 1: one-cycle pulse, request finished.
- `drop` out 1: valid with `ack`; request was not played.
- `ch` out 2: voice used, valid with `ack`.
- `busy` out 1: FSM not in IDLE.
- `wrn` out 1: to jt6295 `wrn`, active low.
- `din` out 8: to jt6295 `din`.
- `dout` in 8: from jt6295 `dout`; bits 3:0 = voice n playing.

## Operation
- Command bytes:
  - Play byte 0 = `{1'b1, phrase}`.
  - Play byte 1 = `{onehot(ch), att}`, where onehot: ch0=0x10, ch1=0x20, ch2=0x40, ch3=0x80.
  - Stop = `{1'b0, mask, 3'b000}`, one byte.
- FSM states: IDLE, PICK, STOP_WR, STOP_GAP, P0_WR, P0_GAP, P1_WR, SETTLE.
- IDLE:
  - `stop_req`=1: latch `stop_mask`, go to STOP_WR. `stop_req` wins over a simultaneous `req`.
  - Else if `req`=1: latch `req_phrase` and `req_att`, go to PICK.
  - A mask of 0 or a phrase of 0 is not written: `ack` is pulsed next cycle (`drop`=1 for phrase 0, `drop`=0 for mask 0), then IDLE.
- PICK (1 cycle): choose the lowest n with `dout[n]`=0. If a voice is found, go to P0_WR with `ch`=n.
- PICK with all four `dout[3:0]`=1:
  - STEAL=0: `ack`+`drop` pulse, go to IDLE.
  - STEAL=1: `ch`=rr, stop mask=onehot(rr), go to STOP_WR; rr increments mod 4. After the stop byte's gap, continue to P0_WR on the same `ch`.
- *_WR: `wrn`=0 for WR_LEN cycles. `din` is driven in the first cycle and held through the following gap.
- *_GAP: `wrn`=1 for WR_GAP cycles.
- Sequencing:
  - P0_GAP → P1_WR.
  - P1_WR → SETTLE. No gap state follows P1_WR; SETTLE provides `wrn` high time.
  - A plain stop: STOP_GAP → SETTLE.
- SETTLE: count SETTLE cycles, then pulse `ack` (`drop`=0) with `ch` valid, then IDLE.
- `req`/`stop_req` are ignored outside IDLE. The requester must deassert in the cycle after `ack`; a request still high in IDLE is treated as new.
- Reset (any state, mid-write included), next cycle:
  - `wrn`=1, `din`=0x00.
  - `ack`=0, `drop`=0, `ch`=0, `busy`=0.
  - rr=0, FSM=IDLE.
  - No partial command is completed. Byte 1 of an interrupted play is never sent.

## Timing
- All outputs are registered. `busy` rises the cycle after a request is latched.
- `wrn` fall in P0_WR happens 2 cycles after `req` is sampled high in IDLE (latch, PICK).
- Play on a free voice: latch (1) + PICK (1) + 2·WR_LEN + WR_GAP + SETTLE cycles to `ack`. With defaults: 1+1+8+8+16 = 34.
- Stop: latch (1) + WR_LEN + WR_GAP + SETTLE cycles to `ack`. With defaults: 29.
- Stolen play = stop timing without SETTLE, plus the play tail: 1+1+4+8+4+8+4+16 = 46 cycles with defaults.
- `dout` is sampled only in PICK. It must reflect the previous command, which SETTLE guarantees when SETTLE ≥ the jt6295 status latency in clk cycles.
- `din` never changes while `wrn`=0.

## Test plan
- Free voice: `dout`=0x03, `req` phrase 1, att 0 → writes 0x81, then 0x40 (ch2); `ack`, `ch`=2, `drop`=0, 34 cycles after the latch.
- Stop: `stop_req` mask 0xF → single write 0x78, `ack` 29 cycles after the latch; no second strobe.
- Full, STEAL=0: `dout`=0x0F, `req` phrase 5 → no `wrn` activity; `ack`+`drop` 2 cycles after `req`.
- Full, STEAL=1, three requests: writes 0x08, 0x85, 0x1x; then 0x10, …, 0x2x; then 0x20, …, 0x4x (rr 0→1→2); all `drop`=0.
- Simultaneous `req` and `stop_req` in IDLE → stop byte issued first; `req` is then serviced after `stop_req` is dropped. Phrase 0 → `drop`=1, no writes.
- `rst` asserted during P0_WR → next cycle `wrn`=1, `din`=0, `busy`=0; byte 1 never appears.
